// File: rtl/tpu_pkg.sv
// Shared definitions for the 2x2 TPU host-side loader: sizes, loader states,
// shadow-bank element indices and frame lengths.
package tpu_pkg;

  localparam int DATA_W  = 8;
  localparam int N_ELEMS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_I,
    ST_FULL
  } loader_state_e;

  localparam logic [2:0] W00 = 3'd0;
  localparam logic [2:0] W01 = 3'd1;
  localparam logic [2:0] W10 = 3'd2;
  localparam logic [2:0] W11 = 3'd3;
  localparam logic [2:0] X00 = 3'd4;
  localparam logic [2:0] X01 = 3'd5;
  localparam logic [2:0] X10 = 3'd6;
  localparam logic [2:0] X11 = 3'd7;

  localparam logic [3:0] FRAME_FULL   = 4'd8;
  localparam logic [3:0] FRAME_INPUTS = 4'd4;

  function automatic logic [3:0] frame_len(input logic keep);
    return keep ? FRAME_INPUTS : FRAME_FULL;
  endfunction

  // Input-only frames start at x00, so their byte position is offset into the input half.
  function automatic logic [2:0] elem_index(input logic keep, input logic [3:0] fill);
    logic [3:0] idx;
    idx = keep ? (fill + {1'b0, X00}) : fill;
    return idx[2:0];
  endfunction

endpackage

// File: rtl/loader_shadow_bank.sv
// Eight write-indexed shadow registers and the commit copy into the active
// weight/input bank; weights are left alone on input-only frames.
module loader_shadow_bank
  import tpu_pkg::*;
#(
  parameter int DATA_W  = tpu_pkg::DATA_W,
  parameter int N_ELEMS = tpu_pkg::N_ELEMS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [2:0]                       wr_idx,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             commit,
  input  logic                             keep_weights,
  output logic [N_ELEMS-1:0][DATA_W-1:0]   act_w,
  output logic [N_ELEMS-1:0][DATA_W-1:0]   act_x
);

  logic [2*N_ELEMS-1:0][DATA_W-1:0] shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (wr_en) begin
      shadow_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_w <= '0;
      act_x <= '0;
    end else if (commit) begin
      act_x[0] <= shadow_q[X00];
      act_x[1] <= shadow_q[X01];
      act_x[2] <= shadow_q[X10];
      act_x[3] <= shadow_q[X11];
      if (!keep_weights) begin
        act_w[0] <= shadow_q[W00];
        act_w[1] <= shadow_q[W01];
        act_w[2] <= shadow_q[W10];
        act_w[3] <= shadow_q[W11];
      end
    end
  end

endmodule

// File: rtl/host_loader.sv
// Host ingress: assembles serial bytes into a shadow weight/input bank and commits
// it to the active registers when the feeder is idle, then pulses start.
module host_loader
  import tpu_pkg::*;
#(
  parameter int DATA_W  = tpu_pkg::DATA_W,
  parameter int N_ELEMS = tpu_pkg::N_ELEMS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              keep_weights,
  input  logic              in_transpose,
  input  logic              abort,
  input  logic              consume_busy,
  output logic [DATA_W-1:0] weight0,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] input0,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [DATA_W-1:0] input3,
  output logic              transpose,
  output logic              start,
  output logic [3:0]        fill_level
);

  loader_state_e state_q, state_nxt;
  logic [3:0]    fill_q;
  logic          keep_q, tp_q;
  logic          start_q, transpose_q;
  logic          hs, commit, abort_frame, keep_sel;
  logic [2:0]    wr_idx;

  logic [N_ELEMS-1:0][DATA_W-1:0] act_w, act_x;

  // rst_n gates in_ready so the host never sees a ready loader during reset.
  assign in_ready    = rst_n && en && !abort && (state_q != ST_FULL);
  assign hs          = in_valid && in_ready;
  assign abort_frame = abort && (state_q != ST_IDLE);
  assign commit      = (state_q == ST_FULL) && !consume_busy && !abort;
  assign keep_sel    = (state_q == ST_IDLE) ? keep_weights : keep_q;
  assign wr_idx      = elem_index(keep_sel, fill_q);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (hs) state_nxt = keep_weights ? ST_LOAD_I : ST_LOAD_W;
      ST_LOAD_W: if (hs && fill_q == FRAME_INPUTS - 4'd1) state_nxt = ST_LOAD_I;
      ST_LOAD_I: if (hs && (fill_q + 4'd1) == frame_len(keep_q)) state_nxt = ST_FULL;
      ST_FULL:   if (!consume_busy) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort_frame) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= '0;
      keep_q      <= 1'b0;
      tp_q        <= 1'b0;
      start_q     <= 1'b0;
      transpose_q <= 1'b0;
    end else begin
      start_q <= commit;
      if (abort_frame || commit) begin
        fill_q <= '0;
      end else if (hs && fill_q < frame_len(keep_sel)) begin
        fill_q <= fill_q + 4'd1;
      end
      // Frame flags are captured only with byte 0.
      if (hs && state_q == ST_IDLE) begin
        keep_q <= keep_weights;
        tp_q   <= in_transpose;
      end
      if (commit) transpose_q <= tp_q;
    end
  end

  loader_shadow_bank #(
    .DATA_W  (DATA_W),
    .N_ELEMS (N_ELEMS)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (hs),
    .wr_idx       (wr_idx),
    .wr_data      (in_data),
    .commit       (commit),
    .keep_weights (keep_q),
    .act_w        (act_w),
    .act_x        (act_x)
  );

  assign weight0    = act_w[0];
  assign weight1    = act_w[1];
  assign weight2    = act_w[2];
  assign weight3    = act_w[3];
  assign input0     = act_x[0];
  assign input1     = act_x[1];
  assign input2     = act_x[2];
  assign input3     = act_x[3];
  assign transpose  = transpose_q;
  assign start      = start_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_host_loader.sv
// Directed bench for host_loader: frame loading, input-only reuse, backpressure,
// abort, enable and asynchronous reset.
module tb_host_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       keep_weights = 1'b0;
  logic       in_transpose = 1'b0;
  logic       abort = 1'b0;
  logic       consume_busy = 1'b0;
  logic       in_ready, transpose, start;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic [3:0] fill_level;
  logic [7:0] w_act [4];
  logic [7:0] x_act [4];

  int n_checks = 0;
  int n_fail   = 0;

  host_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .keep_weights (keep_weights),
    .in_transpose (in_transpose),
    .abort        (abort),
    .consume_busy (consume_busy),
    .weight0      (weight0),
    .weight1      (weight1),
    .weight2      (weight2),
    .weight3      (weight3),
    .input0       (input0),
    .input1       (input1),
    .input2       (input2),
    .input3       (input3),
    .transpose    (transpose),
    .start        (start),
    .fill_level   (fill_level)
  );

  always #5 clk = ~clk;

  always_comb begin
    w_act[0] = weight0; w_act[1] = weight1; w_act[2] = weight2; w_act[3] = weight3;
    x_act[0] = input0;  x_act[1] = input1;  x_act[2] = input2;  x_act[3] = input3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
    n_checks++; if (transpose !== 1'b0) begin n_fail++; $display("FAIL reset_transpose: got %b want 0", transpose); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_act[i] !== 8'h00) begin n_fail++; $display("FAIL reset_weight%0d: got %h want 00", i, w_act[i]); end
      n_checks++; if (x_act[i] !== 8'h00) begin n_fail++; $display("FAIL reset_input%0d: got %h want 00", i, x_act[i]); end
    end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready[%0d]: got %b want 1", i, in_ready); end
      send_byte(8'(i + 1));
      n_checks++; if (fill_level !== 4'(i + 1)) begin n_fail++; $display("FAIL full_fill[%0d]: got %0d want %0d", i, fill_level, i + 1); end
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_in_full: got %b want 0", in_ready); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL full_start_early: got %b want 0", start); end
    tick();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL full_start: got %b want 1", start); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_act[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL full_weight%0d: got %h want %h", i, w_act[i], 8'(i + 1)); end
      n_checks++; if (x_act[i] !== 8'(i + 5)) begin n_fail++; $display("FAIL full_input%0d: got %h want %h", i, x_act[i], 8'(i + 5)); end
    end
    n_checks++; if (transpose !== 1'b0) begin n_fail++; $display("FAIL full_transpose: got %b want 0", transpose); end
    n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL full_fill_clear: got %0d want 0", fill_level); end
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL full_start_width: got %b want 0", start); end
  endtask

  task automatic test_input_only();
    keep_weights = 1'b1;
    in_transpose = 1'b1;
    send_byte(8'h11);
    keep_weights = 1'b0;
    in_transpose = 1'b0;
    send_byte(8'h12);
    send_byte(8'h13);
    send_byte(8'h14);
    n_checks++; if (fill_level !== 4'd4) begin n_fail++; $display("FAIL reuse_fill: got %0d want 4", fill_level); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reuse_ready_full: got %b want 0", in_ready); end
    tick();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL reuse_start: got %b want 1", start); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_act[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL reuse_weight%0d: got %h want %h", i, w_act[i], 8'(i + 1)); end
      n_checks++; if (x_act[i] !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL reuse_input%0d: got %h want %h", i, x_act[i], 8'(8'h11 + i)); end
    end
    n_checks++; if (transpose !== 1'b1) begin n_fail++; $display("FAIL reuse_transpose: got %b want 1", transpose); end
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reuse_start_width: got %b want 0", start); end
  endtask

  task automatic test_backpressure();
    consume_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i));
    in_data  = 8'h99;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", c, in_ready); end
      n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL bp_start[%0d]: got %b want 0", c, start); end
      n_checks++; if (weight0 !== 8'h01 || input0 !== 8'h11) begin n_fail++; $display("FAIL bp_active[%0d]: got %h/%h want 01/11", c, weight0, input0); end
      n_checks++; if (fill_level !== 4'd8) begin n_fail++; $display("FAIL bp_fill[%0d]: got %0d want 8", c, fill_level); end
      tick();
    end
    consume_busy = 1'b0;
    tick();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL bp_start_release: got %b want 1", start); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_act[i] !== 8'(8'h21 + i)) begin n_fail++; $display("FAIL bp_weight%0d: got %h want %h", i, w_act[i], 8'(8'h21 + i)); end
      n_checks++; if (x_act[i] !== 8'(8'h25 + i)) begin n_fail++; $display("FAIL bp_input%0d: got %h want %h", i, x_act[i], 8'(8'h25 + i)); end
    end
    n_checks++; if (transpose !== 1'b0) begin n_fail++; $display("FAIL bp_transpose: got %b want 0", transpose); end
    n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL bp_ninth_byte: fill %0d want 0", fill_level); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL bp_start_width: got %b want 0", start); end
  endtask

  task automatic test_abort();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    n_checks++; if (fill_level !== 4'd3) begin n_fail++; $display("FAIL abort_pre_fill: got %0d want 3", fill_level); end
    in_data  = 8'hDD;
    in_valid = 1'b1;
    abort    = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", in_ready); end
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL abort_fill: got %0d want 0", fill_level); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ready: got %b want 1", in_ready); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL abort_start: got %b want 0", start); end
    n_checks++; if (weight0 !== 8'h21 || input0 !== 8'h25) begin n_fail++; $display("FAIL abort_active: got %h/%h want 21/25", weight0, input0); end
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL abort_start_late: got %b want 0", start); end
    in_transpose = 1'b1;
    send_byte(8'h31);
    in_transpose = 1'b0;
    for (int i = 1; i < 8; i++) send_byte(8'(8'h31 + i));
    tick();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL after_abort_start: got %b want 1", start); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_act[i] !== 8'(8'h31 + i)) begin n_fail++; $display("FAIL after_abort_weight%0d: got %h want %h", i, w_act[i], 8'(8'h31 + i)); end
      n_checks++; if (x_act[i] !== 8'(8'h35 + i)) begin n_fail++; $display("FAIL after_abort_input%0d: got %h want %h", i, x_act[i], 8'(8'h35 + i)); end
    end
    n_checks++; if (transpose !== 1'b1) begin n_fail++; $display("FAIL after_abort_transpose: got %b want 1", transpose); end
    // abort against a ready commit in FULL
    consume_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h41 + i));
    consume_busy = 1'b0;
    abort        = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL abort_full_start: got %b want 0", start); end
    n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL abort_full_fill: got %0d want 0", fill_level); end
    n_checks++; if (weight0 !== 8'h31 || input3 !== 8'h38) begin n_fail++; $display("FAIL abort_full_active: got %h/%h want 31/38", weight0, input3); end
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL abort_full_start_late: got %b want 0", start); end
  endtask

  task automatic test_enable_reset();
    send_byte(8'h51);
    send_byte(8'h52);
    en       = 1'b0;
    in_data  = 8'h53;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready[%0d]: got %b want 0", c, in_ready); end
      tick();
    end
    n_checks++; if (fill_level !== 4'd2) begin n_fail++; $display("FAIL en_fill_hold: got %0d want 2", fill_level); end
    en       = 1'b1;
    in_valid = 1'b0;
    send_byte(8'h53);
    send_byte(8'h54);
    send_byte(8'h55);
    n_checks++; if (fill_level !== 4'd5) begin n_fail++; $display("FAIL rst_pre_fill: got %0d want 5", fill_level); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL rst_mid_fill: got %0d want 0", fill_level); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
    n_checks++; if (transpose !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got tp=%b start=%b want 0/0", transpose, start); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_act[i] !== 8'h00 || x_act[i] !== 8'h00) begin n_fail++; $display("FAIL rst_mid_active%0d: got %h/%h want 00/00", i, w_act[i], x_act[i]); end
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    // a pending commit completes with en low
    consume_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h61 + i));
    en           = 1'b0;
    consume_busy = 1'b0;
    tick();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL en_low_commit_start: got %b want 1", start); end
    n_checks++; if (weight0 !== 8'h61 || input3 !== 8'h68) begin n_fail++; $display("FAIL en_low_commit_active: got %h/%h want 61/68", weight0, input3); end
    en = 1'b1;
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL en_low_start_width: got %b want 0", start); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_input_only();
    test_backpressure();
    test_abort();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/host_loader.md
Name: host_loader

Overview:
- Host-side ingress for the 2x2 TPU datapath; the write-direction counterpart of the feeder's serial result readout.
- Accepts a serial byte stream from the RPi over a valid/ready handshake and assembles a 2x2 weight matrix and a 2x2 input matrix in a shadow bank.
- Commits the shadow bank to the active registers read by the feeder only when the feeder is not consuming them, then pulses start.

Parameters:
- DATA_W, 8, element width in bits.
- N_ELEMS, 4, elements per matrix (2x2, row-major).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; when low, no handshake occurs and state holds.
- in_data  in  DATA_W  host byte.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader can accept a byte.
- keep_weights  in  1  sampled with byte 0 of a frame; 1 = 4-byte input-only frame that reuses the active weights.
- in_transpose  in  1  sampled with byte 0 of a frame; becomes transpose on commit.
- abort  in  1  discard the partial or pending frame.
- consume_busy  in  1  high while the feeder reads the active registers (compute phases 0..2).
- weight0..weight3  out  DATA_W each  active weights w00,w01,w10,w11.
- input0..input3  out  DATA_W each  active inputs x00,x01,x10,x11.
- transpose  out  1  active transpose flag.
- start  out  1  one-cycle pulse: new active matrices valid.
- fill_level  out  4  bytes accepted in the current frame (0..8).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; fill_level 0; start 0; transpose 0; all active and shadow registers 0. in_ready is 0 while in reset.
- A handshake occurs on a rising edge with en && in_valid && in_ready.
- in_ready = en && (state is IDLE, LOAD_W or LOAD_I) && !abort. It is combinational from registered state.
- States:
  - IDLE: on handshake, sample keep_weights and in_transpose into frame flags.
    - keep_weights=0: store the byte in shadow w00, go to LOAD_W, fill_level=1.
    - keep_weights=1: store the byte in shadow x00, go to LOAD_I, fill_level=1.
  - LOAD_W: bytes 1..3 go to shadow w01, w10, w11. After the 4th weight byte, go to LOAD_I.
  - LOAD_I: the next four bytes go to shadow x00..x11. In an input-only frame, x00 has already been taken in IDLE, so only x01..x11 remain. After the last input byte, go to FULL.
  - FULL: in_ready=0. On the first edge where consume_busy=0 (en not required):
    - copy the shadow inputs to active, and the shadow weights to active unless keep_weights was set;
    - copy the frame transpose flag to active;
    - register start=1 for exactly one cycle;
    - clear fill_level to 0 and return to IDLE.
  - While consume_busy=1, hold FULL indefinitely; active registers stay unchanged.
- Latency:
  - last byte handshake at edge t -> FULL after t.
  - if consume_busy=0 at edge t+1 -> active updated and start=1 during cycle t+1..t+2.
  - Minimum: 2 edges from the last byte to the start pulse.
- Frame lengths: 8 bytes normally, 4 bytes with keep_weights. fill_level saturates at the frame length and never wraps.
- Flag timing: keep_weights and in_transpose are ignored after byte 0 of a frame.
- abort, in any non-IDLE state: return to IDLE, fill_level 0, shadow contents don't-care, active registers and transpose unchanged, no start. abort wins over a simultaneous in_valid; that byte is not accepted.
- abort coinciding with commit, in FULL with consume_busy=0: abort wins and no commit occurs.
- en low: no handshakes and the byte position holds; a pending FULL commit still completes.
- start never asserts on two consecutive cycles.
- Active registers change only on a commit edge.
- Reset mid-frame or mid-FULL: everything returns to reset values immediately.

Decomposition:
- Shared package tpu_pkg holds:
  - DATA_W and N_ELEMS;
  - loader state encoding (IDLE, LOAD_W, LOAD_I, FULL);
  - element index constants (W00..W11, X00..X11);
  - frame length constants FRAME_FULL=8 and FRAME_INPUTS=4.
- One natural sub-module, loader_shadow_bank: 8 x DATA_W write-indexed shadow registers plus the commit copy into the active bank, with weight-copy suppression.
- FSM, counter and handshake stay in host_loader.

Test Plan:
- Full frame: send 01,02,03,04,05,06,07,08 with consume_busy=0 and in_transpose=0 → start pulses 2 edges after the last byte; weight0..3=01..04; input0..3=05..08; transpose=0; fill_level returns to 0.
- Input-only reuse: after the full frame, send 4-byte frame 11,12,13,14 with keep_weights=1 and in_transpose=1 → weights stay 01..04; inputs=11..14; transpose=1; one start pulse.
- Backpressure: complete a frame while consume_busy=1 for 5 cycles → in_ready=0 and active unchanged throughout; start fires on the first edge after consume_busy drops; a 9th byte offered during FULL is not accepted.
- Abort: send 3 bytes AA,BB,CC, then abort together with in_valid on byte DD → fill_level=0 and state IDLE; DD not accepted; active unchanged; no start. A following 8-byte frame then loads correctly.
- Reset and enable: assert rst_n=0 mid-frame (fill_level=5) → all outputs 0 immediately. Holding en=0 for 3 cycles with in_valid=1 → in_ready=0 and fill_level holds.
